// File: rtl/pipelined_main_decoder.sv
// Registered RV32I(+M) main decoder at the ID/EX boundary.
// Decodes one instruction per cycle into a registered control bundle, flags
// illegal encodings, and sequences multi-cycle MUL/DIV ops by holding the
// upstream stages until the configured latency has elapsed.
module pipelined_main_decoder #(
   parameter int ENABLE_M   = 1,
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   input  logic        stall_in,
   input  logic        flush,
   output logic        stall_out,
   output logic        md_busy,
   output logic        ctrl_valid,
   output logic        illegal_instr,
   output logic        RegWrite,
   output logic        ALUSrc,
   output logic        MemWrite,
   output logic        Branch,
   output logic        Jump,
   output logic [2:0]  ImmSrc,
   output logic [1:0]  ResultSrc,
   output logic [2:0]  ALUOp,
   output logic [2:0]  LoadType,
   output logic [2:0]  StoreType
);

   // Opcode field without the two fixed low bits (checked separately).
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;

   // Countdown preloads: the op is emitted on the L-th edge, so the busy
   // phase starts at L-1 and emits when it reaches 1.
   localparam logic [4:0] MUL_PRELOAD = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_PRELOAD = 5'(DIV_CYCLES - 1);

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [2:0] imm_src;
      logic [1:0] result_src;
      logic [2:0] alu_op;
      logic [2:0] load_type;
      logic [2:0] store_type;
   } ctrl_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   // Bundle emitted when a sequenced M-op completes.
   localparam ctrl_t MD_BUNDLE = '{valid: 1'b1, reg_write: 1'b1, alu_op: 3'b011, default: '0};

   state_t     r_state;
   logic [4:0] r_cnt;
   ctrl_t      r_out;

   state_t     w_state_nxt;
   logic [4:0] w_cnt_nxt;
   ctrl_t      w_out_nxt;
   ctrl_t      w_dec;
   logic       w_is_mop;
   logic       w_illegal;
   logic [4:0] w_preload;
   logic       w_need_seq;
   logic       w_unused_bits;

   // Only opcode, funct3 and funct7 steer control; register fields pass through elsewhere.
   assign w_unused_bits = ^{instr[24:15], instr[11:7]};

   // Combinational decode of the presented instruction.
   always_comb begin
      w_dec     = '0;
      w_is_mop  = 1'b0;
      w_illegal = 1'b0;
      if (instr[1:0] != 2'b11) begin
         w_illegal = 1'b1;
      end else begin
         case (instr[6:2])
            OPC_LOAD: begin
               w_dec.reg_write  = 1'b1;
               w_dec.alu_src    = 1'b1;
               w_dec.result_src = 2'b01;
               w_dec.load_type  = instr[14:12];
            end
            OPC_STORE: begin
               w_dec.mem_write  = 1'b1;
               w_dec.alu_src    = 1'b1;
               w_dec.imm_src    = 3'b001;
               w_dec.store_type = instr[14:12];
            end
            OPC_OP: begin
               if (instr[31:25] == 7'b0000001) begin
                  if (ENABLE_M != 0) begin
                     w_is_mop        = 1'b1;
                     w_dec.reg_write = 1'b1;
                     w_dec.alu_op    = 3'b011;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end else begin
                  w_dec.reg_write = 1'b1;
                  w_dec.alu_op    = 3'b010;
               end
            end
            OPC_OPIMM: begin
               w_dec.reg_write = 1'b1;
               w_dec.alu_src   = 1'b1;
               w_dec.alu_op    = 3'b010;
            end
            OPC_BRANCH: begin
               w_dec.branch  = 1'b1;
               w_dec.imm_src = 3'b010;
               w_dec.alu_op  = 3'b001;
            end
            OPC_JAL: begin
               w_dec.reg_write  = 1'b1;
               w_dec.jump       = 1'b1;
               w_dec.imm_src    = 3'b100;
               w_dec.result_src = 2'b10;
               w_dec.alu_op     = 3'b110;
            end
            OPC_JALR: begin
               w_dec.reg_write  = 1'b1;
               w_dec.jump       = 1'b1;
               w_dec.alu_src    = 1'b1;
               w_dec.result_src = 2'b10;
            end
            OPC_LUI: begin
               w_dec.reg_write = 1'b1;
               w_dec.alu_src   = 1'b1;
               w_dec.imm_src   = 3'b011;
               w_dec.alu_op    = 3'b100;
            end
            OPC_AUIPC: begin
               w_dec.reg_write = 1'b1;
               w_dec.alu_src   = 1'b1;
               w_dec.imm_src   = 3'b011;
               w_dec.alu_op    = 3'b101;
            end
            default: w_illegal = 1'b1;
         endcase
      end
      if (w_illegal) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
      end
      w_dec.valid = 1'b1;
   end

   // funct3 bit 2 separates MUL* (0-3) from DIV/REM (4-7).
   assign w_preload  = instr[14] ? DIV_PRELOAD : MUL_PRELOAD;
   assign w_need_seq = instr_valid && w_is_mop && (w_preload != 5'd0);

   // Next-state, next-bundle and upstream stall; flush outranks stall_in, which outranks the FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      stall_out   = 1'b0;
      if (flush) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 5'd0;
         w_out_nxt   = '0;
      end else if (stall_in) begin
         stall_out = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_need_seq) begin
                  stall_out   = 1'b1;
                  w_out_nxt   = '0;
                  w_state_nxt = MD_BUSY;
                  w_cnt_nxt   = w_preload;
               end else begin
                  w_out_nxt = instr_valid ? w_dec : '0;
               end
            end
            MD_BUSY: begin
               // instr_valid is deliberately ignored here: the op always completes.
               stall_out = (r_cnt > 5'd1);
               if (r_cnt == 5'd1) begin
                  w_out_nxt   = MD_BUNDLE;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = 5'd0;
               end else begin
                  w_out_nxt = '0;
                  w_cnt_nxt = r_cnt - 5'd1;
               end
            end
            default: begin
               w_out_nxt   = '0;
               w_state_nxt = IDLE;
               w_cnt_nxt   = 5'd0;
            end
         endcase
      end
   end

   // State, countdown and output bundle registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 5'd0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
      end
   end

   assign md_busy       = (r_state == MD_BUSY);
   assign ctrl_valid    = r_out.valid;
   assign illegal_instr = r_out.illegal;
   assign RegWrite      = r_out.reg_write;
   assign ALUSrc        = r_out.alu_src;
   assign MemWrite      = r_out.mem_write;
   assign Branch        = r_out.branch;
   assign Jump          = r_out.jump;
   assign ImmSrc        = r_out.imm_src;
   assign ResultSrc     = r_out.result_src;
   assign ALUOp         = r_out.alu_op;
   assign LoadType      = r_out.load_type;
   assign StoreType     = r_out.store_type;

endmodule

// File: tb/tb_pipelined_main_decoder.sv
// Bench for pipelined_main_decoder: three builds (M with DIV=4, no M, M with
// MUL=3/DIV=1) share one instruction stream; a directed prologue covers the
// listed scenarios and a random phase follows. Expected values come from a
// presentation-count model of each build.
module tb_pipelined_main_decoder;

   typedef struct packed {
      logic       cv;
      logic       ill;
      logic       rw;
      logic       asrc;
      logic       mw;
      logic       br;
      logic       jp;
      logic [2:0] imm;
      logic [1:0] rs;
      logic [2:0] aop;
      logic [2:0] lt;
      logic [2:0] st;
   } bnd_t;

   localparam int ND    = 21;
   localparam int NCYC  = 3000;
   localparam int P_EN [3] = '{1, 0, 1};
   localparam int P_MC [3] = '{1, 1, 3};
   localparam int P_DC [3] = '{4, 4, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        stall_in = 1'b0;
   logic        flush = 1'b0;

   logic so  [3];
   logic mb  [3];
   bnd_t obs [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       cv, ill, rw, asrc, mw, br, jp, s_o, m_b;
      logic [2:0] imm, aop, lt, st;
      logic [1:0] rs;
      pipelined_main_decoder #(
         .ENABLE_M  (P_EN[g]),
         .MUL_CYCLES(P_MC[g]),
         .DIV_CYCLES(P_DC[g])
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .instr        (instr),
         .instr_valid  (instr_valid),
         .stall_in     (stall_in),
         .flush        (flush),
         .stall_out    (s_o),
         .md_busy      (m_b),
         .ctrl_valid   (cv),
         .illegal_instr(ill),
         .RegWrite     (rw),
         .ALUSrc       (asrc),
         .MemWrite     (mw),
         .Branch       (br),
         .Jump         (jp),
         .ImmSrc       (imm),
         .ResultSrc    (rs),
         .ALUOp        (aop),
         .LoadType     (lt),
         .StoreType    (st)
      );
      assign obs[g] = {cv, ill, rw, asrc, mw, br, jp, imm, rs, aop, lt, st};
      assign so[g]  = s_o;
      assign mb[g]  = m_b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference control bundle for a single instruction, straight from the opcode table.
   function automatic bnd_t ref_dec(input logic [31:0] ins, input int en);
      bnd_t b;
      b = '0;
      if (ins[1:0] != 2'b11) begin
         b.ill = 1'b1;
      end else begin
         case (ins[6:0])
            7'h03: begin b.rw = 1; b.asrc = 1; b.rs = 2'd1; b.lt = ins[14:12]; end
            7'h23: begin b.mw = 1; b.asrc = 1; b.imm = 3'd1; b.st = ins[14:12]; end
            7'h33: begin
               if (ins[31:25] != 7'd1)  begin b.rw = 1; b.aop = 3'd2; end
               else if (en != 0)        begin b.rw = 1; b.aop = 3'd3; end
               else                     b.ill = 1'b1;
            end
            7'h13: begin b.rw = 1; b.asrc = 1; b.aop = 3'd2; end
            7'h63: begin b.br = 1; b.imm = 3'd2; b.aop = 3'd1; end
            7'h6F: begin b.rw = 1; b.jp = 1; b.imm = 3'd4; b.rs = 2'd2; b.aop = 3'd6; end
            7'h67: begin b.rw = 1; b.jp = 1; b.asrc = 1; b.rs = 2'd2; end
            7'h37: begin b.rw = 1; b.asrc = 1; b.imm = 3'd3; b.aop = 3'd4; end
            7'h17: begin b.rw = 1; b.asrc = 1; b.imm = 3'd3; b.aop = 3'd5; end
            default: b.ill = 1'b1;
         endcase
      end
      b.cv = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      logic [6:0]  opcs [10];
      int          sel;
      opcs = '{7'h03, 7'h23, 7'h33, 7'h33, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37, 7'h17};
      r   = $urandom;
      sel = $urandom_range(0, 11);
      if (sel < 10) r[6:0] = opcs[sel];
      else if (sel == 10) r[6:0] = 7'h67;
      if (sel == 3 || sel == 4) r[31:25] = 7'b0000001;
      return r;
   endfunction

   // Model state: age = edges the current M-op has been presented (0 when none),
   // mlat = its total latency, mout = expected registered bundle.
   int   age  [3];
   int   mlat [3];
   bnd_t mout [3];

   logic [31:0] d_ins [ND];
   logic        d_v   [ND];
   logic        d_si  [ND];
   logic        d_fl  [ND];
   logic        d_rst [ND];

   task automatic set_d(input int i, input logic [31:0] ins, input logic v,
                        input logic si, input logic fl, input logic r);
      d_ins[i] = ins; d_v[i] = v; d_si[i] = si; d_fl[i] = fl; d_rst[i] = r;
   endtask

   initial begin
      logic        held;
      logic [31:0] ni;
      logic        nv, nsi, nfl, nr;
      held = 1'b0;
      for (int k = 0; k < 3; k++) begin age[k] = 0; mlat[k] = 0; mout[k] = '0; end

      set_d( 0, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1); // reset
      set_d( 1, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0); // ADDI
      set_d( 2, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0); // DIV
      set_d( 3, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d( 4, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d( 5, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d( 6, 32'h022081B3, 1'b1, 1'b0, 1'b0, 1'b0); // MUL
      set_d( 7, 32'h0020A023, 1'b1, 1'b0, 1'b0, 1'b0); // SW
      set_d( 8, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0); // DIV
      set_d( 9, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d(10, 32'h0220C1B3, 1'b1, 1'b0, 1'b1, 1'b0); // flush at cnt=2
      set_d(11, 32'h123450B7, 1'b1, 1'b0, 1'b0, 1'b0); // LUI
      set_d(12, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0); // DIV
      set_d(13, 32'h0220C1B3, 1'b1, 1'b1, 1'b0, 1'b0); // stall_in x2
      set_d(14, 32'h0220C1B3, 1'b1, 1'b1, 1'b0, 1'b0);
      set_d(15, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d(16, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d(17, 32'h0220C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_d(18, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b0); // illegal opcode
      set_d(19, 32'h022081B3, 1'b1, 1'b0, 1'b0, 1'b0); // MUL
      set_d(20, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0); // bubble

      for (int c = 0; c < ND + NCYC; c++) begin
         @(negedge clk);
         if (c < ND) begin
            ni = d_ins[c]; nv = d_v[c]; nsi = d_si[c]; nfl = d_fl[c]; nr = d_rst[c];
         end else begin
            ni  = rnd_instr();
            nv  = ($urandom_range(0, 99) < 85);
            nsi = ($urandom_range(0, 99) < 15);
            nfl = ($urandom_range(0, 99) < 7);
            nr  = ($urandom_range(0, 199) == 0);
         end
         if (!held) begin
            instr       = ni;
            instr_valid = nv;
         end
         rst      = nr;
         stall_in = nsi;
         flush    = nfl;
         #1;
         held = 1'b0;
         for (int k = 0; k < 3; k++) begin
            logic mop, es;
            int   lat;
            mop = (P_EN[k] != 0) && (instr[6:0] == 7'h33) && (instr[31:25] == 7'd1);
            lat = instr[14] ? P_DC[k] : P_MC[k];
            if (flush)        es = 1'b0;
            else if (stall_in) es = 1'b1;
            else if (age[k] > 0) es = (age[k] + 1 < mlat[k]);
            else              es = instr_valid && mop && (lat > 1);
            if (!rst) begin
               chk($sformatf("d%0d stall_out", k), {31'd0, so[k]}, {31'd0, es});
               // During the directed prologue only the DIV=4 builds steer the upstream hold.
               if (c >= ND || k < 2) held |= es;
            end
            if (rst || flush) begin
               age[k] = 0; mout[k] = '0;
            end else if (stall_in) begin
               // everything holds
            end else if (age[k] > 0) begin
               if (age[k] + 1 == mlat[k]) begin
                  mout[k] = '0; mout[k].cv = 1; mout[k].rw = 1; mout[k].aop = 3'd3;
                  age[k]  = 0;
               end else begin
                  mout[k] = '0; age[k] = age[k] + 1;
               end
            end else if (instr_valid && mop && lat > 1) begin
               mout[k] = '0; age[k] = 1; mlat[k] = lat;
            end else begin
               mout[k] = instr_valid ? ref_dec(instr, P_EN[k]) : '0;
            end
         end
         if (rst) held = 1'b0;
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d bundle", k), {11'd0, obs[k]}, {11'd0, mout[k]});
            chk($sformatf("d%0d md_busy", k), {31'd0, mb[k]}, {31'd0, (age[k] > 0)});
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
